data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Memory-side responder for the processor's data accesses: the slave end of a valid/ready load/store request channel.
- Services 64-bit doubleword loads and stores with a fixed, configurable latency.
- Returns each result on a separate valid/ready response channel.
- Stores bytes little-endian and exposes the first five doublewords (array0..array4) continuously, so sort results can be observed.

Parameters:
DEPTH_BYTES, 256, memory size in bytes; multiple of 8, minimum 40
LATENCY, 2, cycles from request acceptance to resp_valid; minimum 1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store doubleword, 0 = load doubleword
req_addr  input  64  byte address
req_wdata  input  64  store data
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  64  load data (0 for stores and errors)
resp_err  output  1  request rejected (misaligned or out of range)
array0  output  64  doubleword at byte address 0
array1  output  64  doubleword at byte address 8
array2  output  64  doubleword at byte address 16
array3  output  64  doubleword at byte address 24
array4  output  64  doubleword at byte address 32

Behaviour:
- Reset (reset low, asynchronous): state IDLE, counter 0, latched request cleared, every memory byte 0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0. After reset deasserts, req_ready=1 in IDLE.
- Reset mid-operation: any in-flight request is discarded and no response is produced. The memory clear takes precedence over any pending store.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1, resp_valid=0.
  - On a rising edge with req_valid=1: latch req_write, req_addr and req_wdata; set counter=LATENCY-1; go to BUSY.
- BUSY:
  - req_ready=0.
  - If counter≠0, decrement it.
  - If counter=0, perform the access, load the response registers and go to RESP.
  - Result: resp_valid rises exactly LATENCY cycles after the accepting edge.
- RESP:
  - resp_valid=1, req_ready=0. resp_rdata and resp_err are held stable.
  - On an edge with resp_ready=1: go to IDLE and drop resp_valid.
  - Next earliest acceptance is the edge after the response handshake, so there is no overlap of requests.
- Error check, applied to the latched address:
  - Error if addr[2:0]≠0 or addr > DEPTH_BYTES-8, evaluated in full 64-bit width with no wrap.
  - On error: resp_err=1, resp_rdata=0, memory unchanged.
- Load: resp_rdata = {mem[a+7],…,mem[a]}, resp_err=0.
- Store:
  - mem[a+i] = wdata[8i+7:8i] for i=0..7, committed on the BUSY→RESP edge.
  - resp_rdata=0, resp_err=0.
- Handshake edge cases:
  - req_valid while req_ready=0 is ignored, not queued; the requester holds it.
  - req_* inputs may change freely after acceptance.
  - resp_ready while resp_valid=0 has no effect.
  - A response held many cycles retains its values.
- arrayK = {mem[8K+7],…,mem[8K]}, combinational from storage; reflects a store from the cycle after its commit edge.
- The load-after-store ordering guarantee follows from single-outstanding operation.

Test Plan:
- Reset then idle: reset low → all outputs 0, array0..4=0. Release → req_ready=1 next cycle, resp_valid=0.
- Store then load: LATENCY=2, store addr 8, data 0x1122334455667788.
  - resp_valid rises 2 cycles after acceptance with err=0, rdata=0, and array1=0x1122334455667788.
  - A following load at addr 8 returns the same value.
  - Byte mem[8]=0x88 confirms little-endian order.
- Response backpressure: hold resp_ready=0 for 5 cycles → resp_valid stays 1 with rdata unchanged and req_ready=0. Drop resp_ready for one cycle then raise it → IDLE, req_ready=1 on the following cycle.
- Error cases, each giving resp_err=1, rdata=0 and no array change:
  - store to addr 4 (misaligned);
  - store to addr DEPTH_BYTES (out of range);
  - load from addr 0xFFFFFFFFFFFFFFF8 (out of range, no wrap).
- Reset mid-BUSY: LATENCY=4, accept a store to addr 0, assert reset 2 cycles later → no response appears, array0=0, FSM in IDLE after release.
- Sort pattern: store 5,3,9,1,7 to addrs 0..32, then store the values reordered → array0..4 read 1,3,5,7,9 and loads return the same values.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Memory-side slave for 64-bit doubleword loads and stores over a
//   valid/ready request channel. Each access completes after a fixed latency
//   and is returned on a separate valid/ready response channel. Only one
//   request is ever outstanding. Storage is byte-addressed, little-endian, and
//   the first five doublewords are exposed continuously for observation.
//
// Ports
//   clk                clock, all state updates on the rising edge
//   reset              asynchronous active-low reset
//   req_valid/ready    request handshake
//   req_write          1 = store doubleword, 0 = load doubleword
//   req_addr           byte address (must be 8-byte aligned and in range)
//   req_wdata          store data
//   resp_valid/ready   response handshake
//   resp_rdata         load data (0 for stores and errors)
//   resp_err           request rejected (misaligned or out of range)
//   array0..array4     doublewords at byte addresses 0, 8, 16, 24, 32
module data_memory_responder #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] array0,
    output logic [63:0] array1,
    output logic [63:0] array2,
    output logic [63:0] array3,
    output logic [63:0] array4
);

    localparam int unsigned NUM_DW = DEPTH_BYTES / 8;
    localparam int unsigned IDX_W  = (NUM_DW > 1) ? $clog2(NUM_DW) : 1;
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [63:0]      MAX_ADDR = 64'(DEPTH_BYTES - 8);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Latched request payload
    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    req_t             lat_req;

    // Accesses are always doubleword-aligned, so storage is kept as
    // doublewords; byte i of a doubleword sits in bits [8i+7:8i] (little-endian).
    logic [63:0] mem [NUM_DW];

    logic             addr_err_c;
    logic [IDX_W-1:0] idx_c;
    logic             accept_c;

    // Full 64-bit comparison so huge addresses cannot wrap into range
    assign addr_err_c = (lat_req.addr[2:0] != 3'b000) || (lat_req.addr > MAX_ADDR);
    assign idx_c      = lat_req.addr[IDX_W+2:3];
    assign accept_c   = req_valid && req_ready;

    // FSM, latency counter, response registers and storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_req    <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            for (int i = 0; i < int'(NUM_DW); i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    if (accept_c) begin
                        lat_req   <= '{write: req_write, addr: req_addr, wdata: req_wdata};
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end

                BUSY: begin
                    req_ready <= 1'b0;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        if (addr_err_c) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (lat_req.write) begin
                            mem[idx_c] <= lat_req.wdata;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else begin
                            resp_err   <= 1'b0;
                            resp_rdata <= mem[idx_c];
                        end
                    end
                end

                RESP: begin
                    // Ready is raised on the handshake edge so the very next
                    // edge can accept a new request.
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Observation taps straight from storage
    assign array0 = mem[0];
    assign array1 = mem[1];
    assign array2 = mem[2];
    assign array3 = mem[3];
    assign array4 = mem[4];

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
//   Directed bench for data_memory_responder. A LATENCY=2 instance runs a
//   table of load/store vectors plus hand-written handshake sequences; a
//   LATENCY=4 instance covers reset arriving while a store is in flight.
module tb_data_memory_responder;

    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=2 instance
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] a0, a1, a2, a3, a4;

    // LATENCY=4 instance
    logic        q_rst_n;
    logic        q_req_valid, q_req_ready, q_req_write;
    logic [63:0] q_req_addr, q_req_wdata;
    logic        q_resp_valid, q_resp_ready, q_resp_err;
    logic [63:0] q_resp_rdata;
    logic [63:0] q_a0, q_a1, q_a2, q_a3, q_a4;

    data_memory_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .array0(a0), .array1(a1), .array2(a2), .array3(a3), .array4(a4)
    );

    data_memory_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(4)) dut4 (
        .clk(clk), .reset(q_rst_n),
        .req_valid(q_req_valid), .req_ready(q_req_ready), .req_write(q_req_write),
        .req_addr(q_req_addr), .req_wdata(q_req_wdata),
        .resp_valid(q_resp_valid), .resp_ready(q_resp_ready),
        .resp_rdata(q_resp_rdata), .resp_err(q_resp_err),
        .array0(q_a0), .array1(q_a1), .array2(q_a2), .array3(q_a3), .array4(q_a4)
    );

    typedef struct {
        logic        w;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    // Present a request, wait for acceptance, scramble inputs, count cycles to resp_valid
    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = ~d;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Response handshake; IDLE and ready again right after the edge
    task automatic complete(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        int lat;
        for (int i = lo; i <= hi; i++) begin
            issue(vecs[i].w, vecs[i].addr, vecs[i].wdata, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
            check($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), 64'(resp_err), 64'(vecs[i].exp_err));
            complete($sformatf("v%0d", i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        int          n;
        logic        saw_valid;
        logic [63:0] hold_rdata;

        // Part A: basic store/load and error cases
        vecs.push_back('{1'b1, 64'd8,   64'h1122334455667788, 64'h0, 1'b0});
        vecs.push_back('{1'b0, 64'd8,   64'h0,                64'h1122334455667788, 1'b0});
        vecs.push_back('{1'b1, 64'd248, 64'hCAFEF00D12345678, 64'h0, 1'b0});
        vecs.push_back('{1'b0, 64'd248, 64'h0,                64'hCAFEF00D12345678, 1'b0});
        vecs.push_back('{1'b1, 64'd4,   64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1});
        vecs.push_back('{1'b1, 64'd256, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1});
        vecs.push_back('{1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0,   64'h0, 1'b1});
        vecs.push_back('{1'b0, 64'd12,  64'h0,                64'h0, 1'b1});
        vecs.push_back('{1'b0, 64'd0,   64'h0,                64'h0, 1'b0});
        // Part B: sort pattern, unsorted stores (9..13)
        vecs.push_back('{1'b1, 64'd0,  64'd5, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 64'd8,  64'd3, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 64'd16, 64'd9, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 64'd24, 64'd1, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 64'd32, 64'd7, 64'h0, 1'b0});
        // Part C: sorted stores (14..18) and loads (19..23)
        vecs.push_back('{1'b1, 64'd0,  64'd1, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 64'd8,  64'd3, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 64'd16, 64'd5, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 64'd24, 64'd7, 64'h0, 1'b0});
        vecs.push_back('{1'b1, 64'd32, 64'd9, 64'h0, 1'b0});
        vecs.push_back('{1'b0, 64'd0,  64'h0, 64'd1, 1'b0});
        vecs.push_back('{1'b0, 64'd8,  64'h0, 64'd3, 1'b0});
        vecs.push_back('{1'b0, 64'd16, 64'h0, 64'd5, 1'b0});
        vecs.push_back('{1'b0, 64'd24, 64'h0, 64'd7, 1'b0});
        vecs.push_back('{1'b0, 64'd32, 64'h0, 64'd9, 1'b0});

        rst_n = 1'b0;  q_rst_n = 1'b0;
        req_valid = 1'b0;  req_write = 1'b0;  req_addr = '0;  req_wdata = '0;  resp_ready = 1'b0;
        q_req_valid = 1'b0;  q_req_write = 1'b0;  q_req_addr = '0;  q_req_wdata = '0;  q_resp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_array_or", a0 | a1 | a2 | a3 | a4, 64'd0);
        rst_n = 1'b1;  q_rst_n = 1'b1;
        @(negedge clk);
        check("rel_req_ready", 64'(req_ready), 64'd1);
        check("rel_resp_valid", 64'(resp_valid), 64'd0);
        check("rel_q_req_ready", 64'(q_req_ready), 64'd1);

        run_vecs(0, 8);
        check("a_array0", a0, 64'd0);
        check("a_array1", a1, 64'h1122334455667788);
        check("a_mem8_byte", 64'(a1[7:0]), 64'h88);
        check("a_array2_4", a2 | a3 | a4, 64'd0);

        // Backpressure: response held 5 cycles while a competing request is ignored
        issue(1'b0, 64'd8, 64'h0, lat);
        check("bp_latency", 64'(lat), 64'd2);
        hold_rdata = resp_rdata;
        check("bp_rdata", hold_rdata, 64'h1122334455667788);
        req_valid = 1'b1;  req_write = 1'b1;  req_addr = 64'd0;  req_wdata = 64'hBAD0BAD0BAD0BAD0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_valid", k), 64'(resp_valid), 64'd1);
            check($sformatf("bp%0d_rdata", k), resp_rdata, hold_rdata);
            check($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_still_valid", 64'(resp_valid), 64'd1);
        complete("bp");
        check("bp_no_queue", a0, 64'd0);

        // resp_ready with no response pending does nothing
        resp_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("idle_resp_ready_valid", 64'(resp_valid), 64'd0);
            check("idle_resp_ready_rdy", 64'(req_ready), 64'd1);
        end
        resp_ready = 1'b0;

        run_vecs(9, 13);
        check("unsorted_a0", a0, 64'd5);
        check("unsorted_a1", a1, 64'd3);
        check("unsorted_a2", a2, 64'd9);
        check("unsorted_a3", a3, 64'd1);
        check("unsorted_a4", a4, 64'd7);
        run_vecs(14, 23);
        check("sorted_a0", a0, 64'd1);
        check("sorted_a1", a1, 64'd3);
        check("sorted_a2", a2, 64'd5);
        check("sorted_a3", a3, 64'd7);
        check("sorted_a4", a4, 64'd9);

        // Reset while a LATENCY=4 store is in flight
        @(negedge clk);
        q_req_valid = 1'b1;  q_req_write = 1'b1;  q_req_addr = 64'd0;  q_req_wdata = 64'hDEADBEEF01234567;
        check("q_ready_pre", 64'(q_req_ready), 64'd1);
        @(posedge clk);
        #1;
        q_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q_rst_n = 1'b0;
        #1;
        check("q_rst_valid", 64'(q_resp_valid), 64'd0);
        check("q_rst_ready", 64'(q_req_ready), 64'd0);
        @(negedge clk);
        q_rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | q_resp_valid;
        end
        check("q_no_resp", 64'(saw_valid), 64'd0);
        check("q_array0", q_a0, 64'd0);
        check("q_idle_ready", 64'(q_req_ready), 64'd1);

        // Normal LATENCY=4 store afterwards
        @(negedge clk);
        q_req_valid = 1'b1;  q_req_write = 1'b1;  q_req_addr = 64'd0;  q_req_wdata = 64'h0123456789ABCDEF;
        @(posedge clk);
        #1;
        q_req_valid = 1'b0;
        n = 0;
        while (!q_resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("q_latency", 64'(n), 64'd4);
        check("q_err", 64'(q_resp_err), 64'd0);
        check("q_array0_new", q_a0, 64'h0123456789ABCDEF);
        q_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        q_resp_ready = 1'b0;
        check("q_valid_drop", 64'(q_resp_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
